data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the CPU data-memory interface: single-port synchronous RAM with programmable wait
//   states, answering the MEM-stage initiator. Decodes the read strobe, 4-bit lane write enables and
//   byte address, stalls the initiator via p_DATA_MemWait, returns read data. Sits beside the core in
//   the SoC/testbench top, port-for-port with the core's data-memory pins.
// PARAMETERS
//   WIDTH       64  data/address width, bits
//   DEPTH_LOG2  10  log2 of RAM depth in WIDTH-bit words (1024 x 64b)
//   LATENCY     2   extra wait cycles per access, legal 0..15
// PORTS
//   p_clk               in   1      clock, all state on rising edge
//   p_rst               in   1      reset, asynchronous, active-high
//   p_DATA_MemAddress   in   WIDTH  byte address from core
//   p_DATA_MemDataOut   in   WIDTH  write data from core
//   p_DATA_MemRead      in   1      read request, level, held by core while Wait high
//   p_DATA_MemWrite     in   4      lane write enables, bit i -> bits [16i+15:16i]
//   p_DATA_MemDataIn    out  WIDTH  read data to core
//   p_DATA_MemWait      out  1      stall to core
//   p_DATA_MemErr       out  1      only with DMEM_MISALIGN_CHK_EN
// BEHAVIOUR
//   - req = p_DATA_MemRead | (|p_DATA_MemWrite). Word index = addr[DEPTH_LOG2+2:3]; addr[2:0] and bits
//     above DEPTH_LOG2+2 ignored (upper-address aliasing/wrap).
//   - FSM IDLE/BUSY/DONE; 4-bit down-counter cnt.
//     IDLE: req -> latch addr, wdata, rd, we; cnt<=LATENCY; -> BUSY. No req -> stay.
//     BUSY: cnt!=0 -> cnt<=cnt-1. cnt==0 -> perform access on latched values; -> DONE.
//     DONE: -> IDLE unconditionally.
//   - p_DATA_MemWait = req & (state!=DONE), combinational. Core sees Wait low in DONE = completion.
//     Wait-high cycles per access = LATENCY+2 (IDLE, LATENCY+1 BUSY); issue-to-issue = LATENCY+3.
//   - Read: data_q <= RAM[idx] at access edge; p_DATA_MemDataIn = data_q, held until next read completes
//     (writes do not change it).
//   - Write: only enabled 16-bit lanes updated; we=4'b0000 is a pure read.
//   - Read+write together: read-before-write; data_q returns old contents, RAM then holds merged data.
//   - Inputs changing in BUSY ignored (latched copy used). Req dropped in BUSY: access still completes
//     (write posted), FSM runs to DONE->IDLE, no stall asserted since req=0.
//   - Req held high through DONE is consumed once; the same req seen in the following IDLE starts a new
//     access, so the core must update/deassert its request the cycle after Wait falls.
//   - Reset (any time, incl. mid-access): state=IDLE, cnt=0, data_q=0, p_DATA_MemDataIn=0,
//     p_DATA_MemErr=0; Wait follows req (high if req present). In-flight access aborted, RAM not written.
//     RAM contents not reset.
//   - LATENCY=0: exactly one BUSY cycle.
// CONFIGURATION
//   DMEM_MISALIGN_CHK_EN defined: p_DATA_MemErr exists; access with latched addr[2:0]!=0 is suppressed
//     at the access edge (no RAM write, data_q unchanged); p_DATA_MemErr=1 during that DONE cycle only,
//     else 0. FSM timing unchanged.
//   Not defined: port absent; addr[2:0] silently ignored, access proceeds.
// TESTING
//   1. Reset mid-BUSY on write 0xAAAA... to 0x40: p_rst high 1 cycle -> IDLE, DataIn=0, RAM[8] unchanged.
//   2. LATENCY=2, write we=4'hF 0x0123456789ABCDEF to 0x10, then read 0x10 -> Wait high 4 cycles,
//      DONE DataIn=0x0123456789ABCDEF.
//   3. RAM[0x10]=0x0123456789ABCDEF; write 0xFFFF_FFFF_FFFF_FFFF we=4'b0101, read -> 0x0123FFFF89ABFFFF.
//   4. Read+write same access to 0x18 (old 0x5, new 0x9, we=4'hF) -> DataIn=0x5; next read -> 0x9.
//   5. DEPTH_LOG2=10: write 0x77 to 0x2000, read 0x0 -> 0x77 (wrap); LATENCY=0 -> Wait high 2 cycles.
//   6. DMEM_MISALIGN_CHK_EN, write to 0x13 -> Err=1 in DONE only, RAM[2] unchanged; aligned -> Err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the CPU data-memory interface. Single-port synchronous
//   RAM (2**DEPTH_LOG2 words of WIDTH bits) with LATENCY programmable wait
//   states. Requests are latched in IDLE, the access happens on the last BUSY
//   edge, and the DONE cycle (Wait low) signals completion to the core.
//
//   Ports
//     p_clk              in   clock, rising edge
//     p_rst              in   asynchronous active-high reset
//     p_DATA_MemAddress  in   byte address, word index = addr[DEPTH_LOG2+2:3]
//     p_DATA_MemDataOut  in   write data
//     p_DATA_MemRead     in   read request (level)
//     p_DATA_MemWrite    in   4 lane write enables, bit i -> 16-bit lane i
//     p_DATA_MemDataIn   out  read data, held until the next read completes
//     p_DATA_MemWait     out  stall, req & (state != DONE)
//     p_DATA_MemErr      out  misaligned-access flag (DMEM_MISALIGN_CHK_EN only)
//
//   Build option: define DMEM_MISALIGN_CHK_EN to add p_DATA_MemErr and
//   suppress accesses whose latched addr[2:0] is nonzero.
module data_mem_responder #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic             p_clk,
    input  logic             p_rst,
    input  logic [WIDTH-1:0] p_DATA_MemAddress,
    input  logic [WIDTH-1:0] p_DATA_MemDataOut,
    input  logic             p_DATA_MemRead,
    input  logic [3:0]       p_DATA_MemWrite,
    output logic [WIDTH-1:0] p_DATA_MemDataIn,
`ifdef DMEM_MISALIGN_CHK_EN
    output logic             p_DATA_MemErr,
`endif
    output logic             p_DATA_MemWait
);

    localparam int         LANE_W = WIDTH / 4;
    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_rd;
    logic [3:0]            r_we;
    logic [WIDTH-1:0]      r_data_q;

    logic                  w_req;
    logic                  w_access;
    logic                  w_ok;
    logic                  w_unused;

    assign w_req    = p_DATA_MemRead | (|p_DATA_MemWrite);
    assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Only the word-index bits of the address are decoded; the rest alias.
    assign w_unused = &{1'b0, p_DATA_MemAddress};

`ifdef DMEM_MISALIGN_CHK_EN
    logic [2:0] r_off;
    logic       r_err;
    assign w_ok          = (r_off == 3'd0);
    assign p_DATA_MemErr = r_err;

    // Error is raised on the access edge and therefore lasts only the DONE cycle.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            r_off <= 3'd0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req)
                r_off <= p_DATA_MemAddress[2:0];
            r_err <= w_access && (r_off != 3'd0);
        end
    end
`else
    assign w_ok = 1'b1;
`endif

    assign p_DATA_MemWait   = w_req & (r_state != S_DONE);
    assign p_DATA_MemDataIn = r_data_q;

    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_we     <= 4'd0;
            r_data_q <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= p_DATA_MemAddress[DEPTH_LOG2+2:3];
                        r_wdata <= p_DATA_MemDataOut;
                        r_rd    <= p_DATA_MemRead;
                        r_we    <= p_DATA_MemWrite;
                        r_cnt   <= LAT;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Reads sample the pre-write contents (read-before-write).
                        if (r_rd && w_ok)
                            r_data_q <= r_mem[r_idx];
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM array is not reset; p_rst only blocks a write on the reset edge.
    always_ff @(posedge p_clk) begin
        if (w_access && w_ok && !p_rst) begin
            for (int l = 0; l < 4; l++) begin
                if (r_we[l])
                    r_mem[r_idx][l*LANE_W +: LANE_W] <= r_wdata[l*LANE_W +: LANE_W];
            end
        end
    end

endmodule
